// File: rtl/gp_register_pkg.sv
// Shared datapath types for loadable register variants and the control unit.
package gp_register_pkg;

  localparam int unsigned FUNSEL_W = 2;

  typedef enum logic [FUNSEL_W-1:0] {
    FS_DEC  = 2'b00,
    FS_INC  = 2'b01,
    FS_LOAD = 2'b10,
    FS_CLR  = 2'b11
  } funsel_t;

endpackage

// File: rtl/gp_register.sv
// N-bit general-purpose register: decrement, increment, parallel load or clear
// on the rising edge when enabled; holds otherwise.
module gp_register
  import gp_register_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [FUNSEL_W-1:0] funsel,
  input  logic [N-1:0]        load,
  output logic [N-1:0]        Q_out
);

  logic [N-1:0] q_next;

  // Next-state select; unknown function codes fall to hold.
  always_comb begin
    q_next = Q_out;
    if (enable) begin
      case (funsel_t'(funsel))
        FS_DEC:  q_next = Q_out - N'(1);
        FS_INC:  q_next = Q_out + N'(1);
        FS_LOAD: q_next = load;
        FS_CLR:  q_next = '0;
        default: q_next = Q_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q_out <= '0;
    end else begin
      Q_out <= q_next;
    end
  end

endmodule

// File: tb/tb_gp_register.sv
// Scoreboard bench for gp_register (N = 8).
module tb_gp_register;
  import gp_register_pkg::*;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [1:0]   funsel;
  logic [N-1:0] load;
  logic [N-1:0] Q_out;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] model_q;
  int unsigned  n_vec;
  int unsigned  n_err;

  gp_register #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .funsel (funsel),
    .load   (load),
    .Q_out  (Q_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: Q_out=%h expected=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_next(input logic [N-1:0] q, input logic en,
                                            input logic [1:0] fs, input logic [N-1:0] ld);
    if (!en) return q;
    if (fs == 2'b00) return (q == '0) ? {N{1'b1}} : q - 8'd1;
    if (fs == 2'b01) return (q == {N{1'b1}}) ? '0 : q + 8'd1;
    if (fs == 2'b10) return ld;
    return '0;
  endfunction

  // Drive one operation between edges, predict, then compare after the edge.
  task automatic apply(input string tag, input logic en, input logic [1:0] fs,
                       input logic [N-1:0] ld);
    @(negedge clk);
    enable = en;
    funsel = fs;
    load   = ld;
    model_q = ref_next(model_q, en, fs, ld);
    exp_q.push_back(model_q);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, Q_out, ~Q_out);
    end else begin
      check(tag, Q_out, exp_q.pop_front());
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    model_q = '0;
    rst_n   = 1'b0;
    enable  = 1'b1;
    funsel  = FS_INC;
    load    = '0;

    // Reset held with increment requested: stays zero.
    #1;
    check("rst_async", Q_out, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", Q_out, 8'h00);
    end
    enable = 1'b0;
    rst_n  = 1'b1;
    apply("rst_inc1", 1'b1, FS_INC, 8'h00);
    check("rst_inc1_const", Q_out, 8'h01);
    apply("rst_inc2", 1'b1, FS_INC, 8'h00);
    check("rst_inc2_const", Q_out, 8'h02);

    // Load then hold through every function code.
    apply("load01", 1'b1, FS_LOAD, 8'h01);
    check("load01_const", Q_out, 8'h01);
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 12; i++)
        apply("hold", 1'b0, 2'(f), 8'hA5);
    check("hold_const", Q_out, 8'h01);

    // Increment and decrement wrap.
    apply("load_fe", 1'b1, FS_LOAD, 8'hFE);
    apply("inc_ff", 1'b1, FS_INC, 8'h00);
    check("inc_ff_const", Q_out, 8'hFF);
    apply("inc_00", 1'b1, FS_INC, 8'h00);
    check("inc_00_const", Q_out, 8'h00);
    apply("inc_01", 1'b1, FS_INC, 8'h00);
    apply("dec_00", 1'b1, FS_DEC, 8'h00);
    apply("dec_ff", 1'b1, FS_DEC, 8'h00);
    check("dec_ff_const", Q_out, 8'hFF);
    apply("dec_fe", 1'b1, FS_DEC, 8'h00);
    check("dec_fe_const", Q_out, 8'hFE);

    // Clear.
    apply("load_5a", 1'b1, FS_LOAD, 8'h5A);
    for (int i = 0; i < 3; i++)
      apply("clr", 1'b1, FS_CLR, 8'h77);
    check("clr_const", Q_out, 8'h00);

    // Enable sweep, 12 cycles per function, from zero.
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 12; i++)
        apply("sweep_en", 1'b1, 2'(f), 8'h01);
    check("sweep_en_const", Q_out, 8'h00);
    for (int i = 0; i < 12; i++) apply("sweep_dec", 1'b1, FS_DEC, 8'h01);
    check("sweep_dec_f4", Q_out, 8'hF4);
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 12; i++)
        apply("sweep_dis", 1'b0, 2'(f), 8'h01);
    check("sweep_dis_const", Q_out, 8'hF4);

    // Random operations.
    for (int i = 0; i < 40; i++)
      apply("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));

    // Asynchronous reset pulse between edges.
    apply("load_33", 1'b1, FS_LOAD, 8'h33);
    @(negedge clk);
    enable = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_mid", Q_out, 8'h00);
    #1;
    rst_n   = 1'b1;
    model_q = '0;
    #1;
    check("arst_after", Q_out, 8'h00);
    apply("arst_inc1", 1'b1, FS_INC, 8'h00);
    apply("arst_inc2", 1'b1, FS_INC, 8'h00);
    check("arst_inc2_const", Q_out, 8'h02);

    check("sb_drained", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
